// File: rtl/text_line_streamer_pkg.sv
// Shared types and constants for the text line streamer.
// Holds the FSM state encoding and the glyph/font geometry used by the
// streamer top level and its glyph shift register.
package text_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int GLYPH_W = 8;                 // pixels per glyph row
    localparam int GLYPH_H = 16;                // rows per glyph
    localparam int BIT_W   = $clog2(GLYPH_W);   // width of the in-glyph bit index
    localparam int ASCII_W = 7;                 // string ROM data width
    localparam int ROW_W   = $clog2(GLYPH_H);   // glyph row select width
    localparam int FONT_AW = ASCII_W + ROW_W;   // font ROM address {code, row}

    localparam logic [ASCII_W-1:0] BLANK_CODE = 7'h00;

endpackage

// File: rtl/text_line_streamer_if.sv
// Pixel stream interface between the text line streamer and the overlay
// line buffer.
//   pix_valid : pixel available (producer)
//   pix_ready : consumer takes the pixel when pix_valid && pix_ready
//   pix_on    : pixel bit, 1 = foreground (producer)
//   pix_col   : pixel column within the line (producer)
// Modports: master = producer (streamer), slave = consumer (line buffer).
interface text_line_streamer_if #(
    parameter int COL_W = 7
);
    logic             pix_valid;
    logic             pix_ready;
    logic             pix_on;
    logic [COL_W-1:0] pix_col;

    modport master (
        output pix_valid,
        output pix_on,
        output pix_col,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_on,
        input  pix_col,
        output pix_ready
    );
endinterface

// File: rtl/text_line_streamer_glyph_shifter.sv
// Glyph row shift register for the text line streamer.
// Loads one 8-bit glyph row (or an empty row for the blank code) and shifts
// it out MSB-first, one bit per accepted pixel, tracking the bit index.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   load       : capture load_data (or zeros when blank) and clear bit_idx
//   blank      : current character is the blank code, force an empty row
//   load_data  : glyph row from the font ROM
//   advance    : pixel handshake, shift left and step bit_idx
//   msb        : current pixel bit
//   bit_idx    : index of the current pixel inside the glyph
//   last       : current pixel is the final one of the glyph
module glyph_shifter
    import text_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               blank,
    input  logic [GLYPH_W-1:0] load_data,
    input  logic               advance,
    output logic               msb,
    output logic [BIT_W-1:0]   bit_idx,
    output logic               last
);

    logic [GLYPH_W-1:0] shift_r;
    logic [BIT_W-1:0]   bit_idx_r;

    // Shift register and bit index; load wins over advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_r   <= '0;
            bit_idx_r <= '0;
        end else if (load) begin
            shift_r   <= blank ? '0 : load_data;
            bit_idx_r <= '0;
        end else if (advance) begin
            shift_r   <= {shift_r[GLYPH_W-2:0], 1'b0};
            bit_idx_r <= bit_idx_r + BIT_W'(1);
        end
    end

    assign msb     = shift_r[GLYPH_W-1];
    assign bit_idx = bit_idx_r;
    assign last    = (bit_idx_r == BIT_W'(GLYPH_W - 1));

endmodule

// File: rtl/text_line_streamer.sv
// Text line streamer: on start, walks the string ROM over all characters,
// fetches each character's glyph row from the (registered) font ROM and
// streams the row bits MSB-first as pixels on a valid/ready handshake.
// Ports:
//   Clk, Reset : clock and synchronous active-high reset
//   start, row : request one glyph row of the whole string; row latched on accept
//   busy, done : line in flight / one-cycle completion pulse
//   str_addr   : string ROM address (current character index)
//   str_data   : ASCII code from the combinational string ROM
//   font_addr  : {str_data, latched row} to the font ROM
//   font_data  : font ROM row bits, valid one cycle after font_addr
//   pix        : pixel stream (master side)
// COL_W must cover NUM_CHARS*GLYPH_W columns.
module text_line_streamer
    import text_pkg::*;
#(
    parameter int NUM_CHARS = 12,
    parameter int STR_AW    = 4,
    parameter int COL_W     = 7
)(
    input  logic                Clk,
    input  logic                Reset,
    input  logic                start,
    input  logic [ROW_W-1:0]    row,
    output logic                busy,
    output logic                done,
    output logic [STR_AW-1:0]   str_addr,
    input  logic [ASCII_W-1:0]  str_data,
    output logic [FONT_AW-1:0]  font_addr,
    input  logic [GLYPH_W-1:0]  font_data,
    text_line_streamer_if.master pix
);

    state_t              state_r;
    state_t              next_state_s;
    logic [STR_AW-1:0]   char_idx_r;
    logic [ROW_W-1:0]    row_r;

    logic                hs_s;
    logic                load_s;
    logic                blank_s;
    logic                last_bit_s;
    logic                last_char_s;
    logic                shift_msb_s;
    logic [BIT_W-1:0]    bit_idx_s;

    // pix_valid is a pure state decode, so pix_ready only qualifies the advance.
    assign hs_s        = (state_r == SHIFT) && pix.pix_ready;
    assign load_s      = (state_r == WAIT);
    assign blank_s     = (str_data == BLANK_CODE);
    assign last_char_s = (char_idx_r == STR_AW'(NUM_CHARS - 1));
    assign font_addr   = {str_data, row_r};

    glyph_shifter u_glyph_shifter (
        .clk       (Clk),
        .reset     (Reset),
        .load      (load_s),
        .blank     (blank_s),
        .load_data (font_data),
        .advance   (hs_s),
        .msb       (shift_msb_s),
        .bit_idx   (bit_idx_s),
        .last      (last_bit_s)
    );

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; start outside IDLE is simply not looked at.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = FETCH;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: next_state_s = WAIT;
            WAIT:  next_state_s = SHIFT;
            SHIFT: begin
                if (hs_s && last_bit_s) begin
                    if (last_char_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = FETCH;
                    end
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Character index and latched glyph row.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            char_idx_r <= '0;
            row_r      <= '0;
        end else if ((state_r == IDLE) && start) begin
            char_idx_r <= '0;
            row_r      <= row;
        end else if (hs_s && last_bit_s && !last_char_s) begin
            char_idx_r <= char_idx_r + STR_AW'(1);
        end
    end

    // FSM output decode; everything is zero unless the state drives it.
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        str_addr      = '0;
        pix.pix_valid = 1'b0;
        pix.pix_on    = 1'b0;
        pix.pix_col   = '0;
        case (state_r)
            IDLE: begin
                str_addr = '0;
            end
            FETCH, WAIT: begin
                busy     = 1'b1;
                str_addr = char_idx_r;
            end
            SHIFT: begin
                busy          = 1'b1;
                str_addr      = char_idx_r;
                pix.pix_valid = 1'b1;
                pix.pix_on    = shift_msb_s;
                pix.pix_col   = COL_W'(char_idx_r) * COL_W'(GLYPH_W) + COL_W'(bit_idx_s);
            end
            DONE: begin
                done     = 1'b1;
                str_addr = char_idx_r;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_text_line_streamer.sv
// Directed self-checking bench for text_line_streamer with a combinational
// string ROM model and a registered font ROM model.
module tb_text_line_streamer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [3:0]  row;
    logic        busy;
    logic        done;
    logic [3:0]  str_addr;
    logic [6:0]  str_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;

    logic [6:0]  str_rom [0:15];
    logic        font_mode;   // 0: 8'hA5 at 11'h735 else addr^8'h3C, 1: all 8'hFF
    int          checks_cnt = 0;
    int          errors_cnt = 0;

    text_line_streamer_if #(.COL_W(7)) pix_if ();

    text_line_streamer #(.NUM_CHARS(12), .STR_AW(4), .COL_W(7)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .row       (row),
        .busy      (busy),
        .done      (done),
        .str_addr  (str_addr),
        .str_data  (str_data),
        .font_addr (font_addr),
        .font_data (font_data),
        .pix       (pix_if)
    );

    always #5 Clk = ~Clk;

    function automatic logic [7:0] font_fn(input logic m, input logic [10:0] a);
        if (m) return 8'hFF;
        if (a == 11'h735) return 8'hA5;
        return a[7:0] ^ 8'h3C;
    endfunction

    assign str_data = str_rom[str_addr];

    always @(posedge Clk) font_data <= font_fn(font_mode, font_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic exp_pix(input int col, input logic [3:0] r);
        logic [6:0] code;
        logic [7:0] fd;
        int ch;
        int b;
        ch   = col / 8;
        b    = col % 8;
        code = (ch < 16) ? str_rom[ch] : 7'h00;
        fd   = (code == 7'h00) ? 8'h00 : font_fn(font_mode, {code, r});
        return fd[7-b];
    endfunction

    // Streams one full line with pix_ready=1 and checks every pixel and done.
    task automatic run_line(input logic [3:0] r, input int inject_at);
        int pix_cnt;
        int done_cnt;
        pix_cnt  = 0;
        done_cnt = 0;
        row   = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("font_addr_t1", 32'(font_addr), 32'({str_rom[0], r}));
        check_eq("busy_t1", 32'(busy), 32'd1);
        for (int cyc = 1; cyc <= 135; cyc++) begin
            if (cyc == inject_at) begin
                start = 1'b1;
                row   = ~r;
            end else begin
                start = 1'b0;
            end
            if (pix_if.pix_valid && pix_if.pix_ready) begin
                check_eq("pix_col", 32'(pix_if.pix_col), 32'(pix_cnt));
                check_eq("pix_on", 32'(pix_if.pix_on), 32'(exp_pix(pix_cnt, r)));
                pix_cnt++;
            end
            if (done) begin
                done_cnt++;
                check_eq("done_cycle", 32'(cyc), 32'd121);
                check_eq("busy_at_done", 32'(busy), 32'd0);
            end
            if (cyc == 120) check_eq("busy_last_shift", 32'(busy), 32'd1);
            if (cyc == 122) check_eq("busy_after_done", 32'(busy), 32'd0);
            tick();
        end
        check_eq("pix_count", 32'(pix_cnt), 32'd96);
        check_eq("done_count", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        logic [7:0] pat;
        logic       seen;
        logic       bad;
        str_rom[0]  = 7'h73; str_rom[1]  = 7'h63; str_rom[2]  = 7'h6F; str_rom[3]  = 7'h72;
        str_rom[4]  = 7'h65; str_rom[5]  = 7'h20; str_rom[6]  = 7'h31; str_rom[7]  = 7'h32;
        str_rom[8]  = 7'h33; str_rom[9]  = 7'h34; str_rom[10] = 7'h21; str_rom[11] = 7'h00;
        for (int i = 12; i < 16; i++) str_rom[i] = 7'h00;
        font_mode        = 1'b0;
        pix_if.pix_ready = 1'b1;
        row              = 4'd0;

        // Reset held 3 cycles with start high: nothing may start.
        Reset = 1'b1;
        start = 1'b1;
        #1;
        repeat (3) tick();
        Reset = 1'b0;
        start = 1'b0;
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_valid", 32'(pix_if.pix_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_str_addr", 32'(str_addr), 32'd0);
        repeat (3) tick();
        check_eq("rst_idle_valid", 32'(pix_if.pix_valid), 32'd0);

        // Row 5 of 's': font_addr 11'h735 -> 8'hA5, with a 3-cycle stall at col 3.
        row   = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("fa_735", 32'(font_addr), 32'h735);
        tick();
        tick();
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check_eq("a5_valid", 32'(pix_if.pix_valid), 32'd1);
            check_eq("a5_col", 32'(pix_if.pix_col), 32'(i));
            check_eq("a5_on", 32'(pix_if.pix_on), 32'(pat[7-i]));
            if (i == 3) begin
                pix_if.pix_ready = 1'b0;
                repeat (3) begin
                    tick();
                    check_eq("stall_valid", 32'(pix_if.pix_valid), 32'd1);
                    check_eq("stall_col", 32'(pix_if.pix_col), 32'd3);
                    check_eq("stall_on", 32'(pix_if.pix_on), 32'd0);
                end
                pix_if.pix_ready = 1'b1;
            end
            tick();
        end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        check_eq("a5_line_done", 32'(seen), 32'd1);
        tick();

        // Full lines with an all-ones font; second run injects start at T+20.
        font_mode = 1'b1;
        run_line(4'd9, 0);
        run_line(4'd2, 20);

        // Reset mid-line while col 40 is presented.
        row   = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (pix_if.pix_valid && pix_if.pix_col == 7'd40) seen = 1'b1;
            else tick();
        end
        check_eq("col40_seen", 32'(seen), 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_eq("mid_rst_valid", 32'(pix_if.pix_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_done", 32'(done), 32'd0);
        check_eq("mid_rst_str_addr", 32'(str_addr), 32'd0);
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (done || pix_if.pix_valid) bad = 1'b1;
        end
        check_eq("mid_rst_quiet", 32'(bad), 32'd0);

        // Restart after reset begins again at char 0 / col 0.
        font_mode = 1'b0;
        run_line(4'd5, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
